// File: rtl/pll_lock_rst_gen.sv
// PLL lock supervisor: pulses pll_rst, qualifies pll_lock over a stability window, then releases sys_rst.
// Outputs registered from next state; `define PLL_LOCK_FILTER_EN to ignore lock dropouts shorter than GLITCH_CYCLES.
module pll_lock_rst_gen #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int GLITCH_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clkin1,
    input  logic             rst,
    input  logic             pll_lock,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             lock_ok,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int MAX_A  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_T  = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int TMR_W  = $clog2(MAX_T + 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               sync1_q, sync1_d;
    logic               lock_s_q, lock_s_d;
    logic [CNT_W-1:0]   retry_q, retry_d;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_q, sys_rst_d;
    logic               lock_ok_q, lock_ok_d;
    logic               loss_det;

`ifdef PLL_LOCK_FILTER_EN
    localparam int GCNT_W = $clog2(GLITCH_CYCLES + 1);
    logic [GCNT_W-1:0]  gcnt_q, gcnt_d;

    // Consecutive low lock samples while running; the GLITCH_CYCLES-th one is a loss.
    always_comb begin
        gcnt_d   = '0;
        loss_det = 1'b0;
        if (state_q == RUN && !lock_s_q) begin
            gcnt_d   = gcnt_q + GCNT_W'(1);
            loss_det = (gcnt_q == GCNT_W'(GLITCH_CYCLES - 1));
        end
    end

    always_ff @(posedge clkin1) begin
        if (rst) gcnt_q <= '0;
        else     gcnt_q <= gcnt_d;
    end
`else
    always_comb begin
        loss_det = !lock_s_q;
    end
`endif

    always_comb begin
        sync1_d  = pll_lock;
        lock_s_d = sync1_q;
        state_d  = state_q;
        tmr_d    = tmr_q + TMR_W'(1);
        retry_d  = retry_q;
        loss_d   = loss_q;

        case (state_q)
            RESET_PLL: begin
                if (tmr_q == TMR_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // A lock sample in the timeout cycle takes priority over the retry.
                if (lock_s_q) begin
                    state_d = STABLE;
                end else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = RESET_PLL;
                    if (retry_q != '1) retry_d = retry_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!lock_s_q)                                 state_d = WAIT_LOCK;
                else if (tmr_q == TMR_W'(STABLE_CYCLES - 1))   state_d = RUN;
            end
            RUN: begin
                tmr_d = tmr_q;
                if (loss_det) begin
                    state_d = RESET_PLL;
                    if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
                end
            end
            default: state_d = RESET_PLL;
        endcase

        if (state_d != state_q) tmr_d = '0;

        pll_rst_d = (state_d == RESET_PLL);
        sys_rst_d = (state_d != RUN);
        lock_ok_d = (state_d == RUN);
    end

    always_ff @(posedge clkin1) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            tmr_q     <= '0;
            sync1_q   <= 1'b0;
            lock_s_q  <= 1'b0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            lock_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            sync1_q   <= sync1_d;
            lock_s_q  <= lock_s_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            lock_ok_q <= lock_ok_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign lock_ok   = lock_ok_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// Scoreboard bench for pll_lock_rst_gen: expected output-change events (cycle + values) are queued by
// the stimulus; a monitor pops one each time any output changes. Honours PLL_LOCK_FILTER_EN.
module tb_pll_lock_rst_gen;

    localparam int RSTC = 16;
    localparam int TOUT = 400;
    localparam int STBL = 1024;
    localparam int GLCH = 4;
    localparam int CW   = 2;
`ifdef PLL_LOCK_FILTER_EN
    localparam int D    = 2 + GLCH;
    localparam int DROP = GLCH;
`else
    localparam int D    = 3;
    localparam int DROP = 1;
`endif

    typedef struct packed {
        logic [31:0]   cyc;
        logic          pll;
        logic          sys;
        logic          ok;
        logic [CW-1:0] retry;
        logic [CW-1:0] loss;
    } ev_t;

    logic          clk;
    logic          rst;
    logic          pll_lock;
    logic          pll_rst;
    logic          sys_rst;
    logic          lock_ok;
    logic [CW-1:0] retry_cnt;
    logic [CW-1:0] loss_cnt;

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    ev_t exp_q[$];
    logic [2*CW+2:0] prev_o = 'x;

    pll_lock_rst_gen #(
        .RST_CYCLES   (RSTC),
        .LOCK_TIMEOUT (TOUT),
        .STABLE_CYCLES(STBL),
        .GLITCH_CYCLES(GLCH),
        .CNT_W        (CW)
    ) dut (
        .clkin1   (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .lock_ok  (lock_ok),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_ev(input int c, input logic p, input logic s, input logic o,
                                      input int r, input int l);
        ev_t e;
        e.cyc   = c;
        e.pll   = p;
        e.sys   = s;
        e.ok    = o;
        e.retry = CW'(r);
        e.loss  = CW'(l);
        exp_q.push_back(e);
    endfunction

    task automatic wait_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every change on any output is one observed event.
    always @(negedge clk) begin
        ev_t cur;
        ev_t e;
        if (cyc > 0) begin
            cur = '{cyc, pll_rst, sys_rst, lock_ok, retry_cnt, loss_cnt};
            if ({pll_rst, sys_rst, lock_ok, retry_cnt, loss_cnt} !== prev_o) begin
                prev_o = {pll_rst, sys_rst, lock_ok, retry_cnt, loss_cnt};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: got cyc=%0d pll_rst=%b sys_rst=%b lock_ok=%b retry=%0d loss=%0d, expected none",
                             cur.cyc, cur.pll, cur.sys, cur.ok, cur.retry, cur.loss);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        miscompares++;
                        $display("FAIL event: got cyc=%0d pll_rst=%b sys_rst=%b lock_ok=%b retry=%0d loss=%0d, expected cyc=%0d pll_rst=%b sys_rst=%b lock_ok=%b retry=%0d loss=%0d",
                                 cur.cyc, cur.pll, cur.sys, cur.ok, cur.retry, cur.loss,
                                 e.cyc, e.pll, e.sys, e.ok, e.retry, e.loss);
                    end
                end
            end
        end
    end

    initial begin
        int r0, l, s, n, w, q;
        ev_t e;
        rst      = 1'b1;
        pll_lock = 1'b0;

        // Reset values appear at the first edge; rst falls after edge r0.
        r0 = 5;
        expect_ev(1, 1, 1, 0, 0, 0);
        expect_ev(r0 + RSTC, 0, 1, 0, 0, 0);
        expect_ev(r0 + 100 + 3 + STBL, 0, 0, 1, 0, 0);
        wait_to(r0);
        rst = 1'b0;
        wait_to(r0 + 100);
        pll_lock = 1'b1;

        // Loss in RUN, then a lock bounce at cycle 500 of the requalification window.
        l = 1200;
`ifdef PLL_LOCK_FILTER_EN
        wait_to(l);
        pll_lock = 1'b0;
        wait_to(l + GLCH - 1);
        pll_lock = 1'b1;
        l = l + 50;
`endif
        s = l + D + RSTC + 1;
        expect_ev(l + D, 1, 1, 0, 0, 1);
        expect_ev(l + D + RSTC, 0, 1, 0, 0, 1);
        expect_ev(s + 500 + 3 + 10 + STBL, 0, 0, 1, 0, 1);
        wait_to(l);
        pll_lock = 1'b0;
        wait_to(l + DROP);
        pll_lock = 1'b1;
        wait_to(s + 500);
        pll_lock = 1'b0;
        wait_to(s + 510);
        pll_lock = 1'b1;

        // Permanent loss: lock never returns, five timeouts, retry saturates at 3.
        n = s + 513 + STBL + 20;
        w = n + D + RSTC;
        expect_ev(n + D, 1, 1, 0, 0, 2);
        expect_ev(w, 0, 1, 0, 0, 2);
        for (int k = 1; k <= 5; k++) begin
            expect_ev(w + (RSTC + TOUT) * k - RSTC, 1, 1, 0, (k > 3) ? 3 : k, 2);
            expect_ev(w + (RSTC + TOUT) * k, 0, 1, 0, (k > 3) ? 3 : k, 2);
        end
        wait_to(n);
        pll_lock = 1'b0;

        // One-cycle mid-run reset clears everything and restarts the sequence.
        q = w + 5 * (RSTC + TOUT) + 20;
        expect_ev(q + 1, 1, 1, 0, 0, 0);
        expect_ev(q + 1 + RSTC, 0, 1, 0, 0, 0);
        wait_to(q);
        rst = 1'b1;
        wait_to(q + 1);
        rst = 1'b0;

        wait_to(q + 60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got nothing, expected cyc=%0d pll_rst=%b sys_rst=%b lock_ok=%b retry=%0d loss=%0d",
                     e.cyc, e.pll, e.sys, e.ok, e.retry, e.loss);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
